// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver FSM states, parity mode encodings
// and the idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int CHECK_NONE = 0;
    localparam int CHECK_ODD  = 1;
    localparam int CHECK_EVEN = 2;

    localparam logic IDLE_LEVEL = 1'b1;

    // Modes other than odd/even carry no parity bit on the line.
    function automatic logic has_parity(input int check);
        return (check == CHECK_ODD) || (check == CHECK_EVEN);
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator shared by the UART transmitter and receiver.
// Even mode returns the XOR-reduce of the data, odd mode its inverse, none returns 0.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHECK      = CHECK_NONE
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_parity
);

    logic xor_red;

    assign xor_red = ^i_data;

    always_comb begin
        o_parity = 1'b0;
        if (CHECK == CHECK_EVEN) begin
            o_parity = xor_red;
        end else if (CHECK == CHECK_ODD) begin
            o_parity = ~xor_red;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one bit per i_clk cycle, start / data LSB-first / optional parity / stop.
// Every output is registered from the next-state decode so the line never glitches.
//
// Handshake: a byte is accepted on a rising edge of i_clk where i_user_tx_valid and
// o_user_tx_ready are both high; the source must hold i_user_tx_data stable while
// valid is high and ready is low, and the byte is captured exactly once at acceptance.
module uart_tx
    import uart_pkg::*;
#(
    parameter int UART_DATA_WIDTH = 8,
    parameter int UART_STOP_WIDTH = 1,
    parameter int UART_CHECK      = CHECK_NONE
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                       i_user_tx_valid,
    output logic                       o_user_tx_ready,
    output logic                       o_uart_tx,
    output logic                       o_user_tx_busy,
    output uart_state_e                o_dbg_state
);

    localparam logic       USE_PARITY = has_parity(UART_CHECK);
    localparam logic [3:0] LAST_BIT   = 4'(UART_DATA_WIDTH - 1);
    localparam logic [1:0] LAST_STOP  = 2'(UART_STOP_WIDTH - 1);

    uart_state_e                state_q, state_d;
    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [1:0]                 stop_cnt_q, stop_cnt_d;
    logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                       parity_q, parity_d;
    logic                       tx_q, tx_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       accept;
    logic                       load;
    logic                       parity_in;

    // Parity is taken from the input byte so it reflects exactly what was accepted.
    uart_parity_calc #(
        .DATA_WIDTH (UART_DATA_WIDTH),
        .CHECK      (UART_CHECK)
    ) u_parity (
        .i_data   (i_user_tx_data),
        .o_parity (parity_in)
    );

    assign accept = i_user_tx_valid && ready_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d    = USE_PARITY ? PARITY : STOP;
                    stop_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            PARITY: begin
                state_d    = STOP;
                stop_cnt_d = '0;
            end
            STOP: begin
                if (stop_cnt_q == LAST_STOP) begin
                    // Accepting here lets the next start bit follow the stop bit with no gap.
                    if (accept) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d    = i_user_tx_data;
            parity_d   = parity_in;
            bit_cnt_d  = '0;
            stop_cnt_d = '0;
        end
    end

    // Output registers are loaded from the next state, so they line up with state_q.
    always_comb begin
        tx_d    = IDLE_LEVEL;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        case (state_d)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    ready_d = (stop_cnt_d == LAST_STOP);
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_uart_tx       = tx_q;
    assign o_user_tx_ready = ready_q;
    assign o_user_tx_busy  = busy_q;
    assign o_dbg_state     = state_q;

endmodule
